// File: rtl/tank_ctrl_mk2.sv
// rtl/tank_ctrl_mk2.sv - player tank controller: tile-collided movement, fire cooldown, hp/lives and respawn life-cycle
module tank_ctrl_mk2 #(
  parameter logic [9:0] INIX          = 10'd32,
  parameter logic [9:0] INIY          = 10'd32,
  parameter int         PLAYER_INDEX  = 0,
  parameter int         TILE          = 32,
  parameter int         MAP_W         = 16,
  parameter int         MAP_H         = 16,
  parameter int         STEP          = 4,
  parameter int         MOVE_PERIOD   = 2,
  parameter int         FIRE_COOLDOWN = 8,
  parameter int         MAX_HP        = 3,
  parameter int         LIVES         = 3,
  parameter int         INVULN_TICKS  = 60,
  parameter int         RESPAWN_TICKS = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   game_over,
  input  logic                   hit,
  input  logic [MAP_W*MAP_H-1:0] map_walls,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   fire,
  output logic                   bullet_fire,
  output logic [1:0]             bullet_direction,
  output logic [9:0]             pos_x,
  output logic [9:0]             pos_y,
  output logic [2:0]             lives_left,
  output logic [31:0]            tank_state
);

  function automatic int cw(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  localparam int NB  = MAP_W * MAP_H;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int MW  = cw(MOVE_PERIOD - 1);
  localparam int FW  = cw(FIRE_COOLDOWN);
  localparam int IVW = cw(INVULN_TICKS);
  localparam int RSW = cw(RESPAWN_TICKS);

  localparam logic [MW-1:0]  MOVE_LAST = MW'(MOVE_PERIOD - 1);
  localparam logic [FW-1:0]  FC0       = FW'(FIRE_COOLDOWN);
  localparam logic [IVW-1:0] INV0      = IVW'(INVULN_TICKS);
  localparam logic [RSW-1:0] RSP0      = RSW'(RESPAWN_TICKS);
  localparam logic [1:0]     HP0       = 2'(MAX_HP);
  localparam logic [2:0]     LIVES0    = 3'(LIVES);
  localparam logic [1:0]     PIDX      = 2'(PLAYER_INDEX);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'b00,
    ST_INVULN = 2'b01,
    ST_DEAD   = 2'b10,
    ST_OUT    = 2'b11
  } state_e;

  state_e         fsm_q;
  logic [9:0]     pos_x_q, pos_y_q;
  logic [1:0]     dir_q, hp_q, bullet_dir_q;
  logic [2:0]     lives_q, anim_q;
  logic [IVW-1:0] inv_cnt_q;
  logic [RSW-1:0] rsp_cnt_q;
  logic [FW-1:0]  fire_cd_q;
  logic [MW-1:0]  move_cnt_q;
  logic           bullet_fire_q;

  logic [9:0]     pos_x_d, pos_y_d;
  logic [1:0]     req_dir;
  logic           any_dir, blocked, active, fatal_hit, fire_ok;
  int             cx, cy;

  // Out-of-map tiles read as walls so the box never leaves the playfield.
  function automatic logic wall_at(input int tx, input int ty);
    int   i;
    logic w;
    i = ty * MAP_W + tx;
    w = 1'b1;
    if (tx >= 0 && ty >= 0 && tx < MAP_W && ty < MAP_H)
      w = map_walls[i[IW-1:0]];
    return w;
  endfunction

  always_comb begin
    any_dir = up | down | left | right;
    cx      = int'(pos_x_q);
    cy      = int'(pos_y_q);
    req_dir = dir_q;
    if (up) begin
      req_dir = 2'b00;
      cy      = cy - STEP;
    end else if (down) begin
      req_dir = 2'b01;
      cy      = cy + STEP;
    end else if (left) begin
      req_dir = 2'b10;
      cx      = cx - STEP;
    end else if (right) begin
      req_dir = 2'b11;
      cx      = cx + STEP;
    end
    blocked = (cx < 0) || (cy < 0) || (cx + TILE > MAP_W * TILE) || (cy + TILE > MAP_H * TILE);
    if (!blocked)
      blocked = wall_at(cx / TILE, cy / TILE) || wall_at((cx + TILE - 1) / TILE, cy / TILE) ||
                wall_at(cx / TILE, (cy + TILE - 1) / TILE) ||
                wall_at((cx + TILE - 1) / TILE, (cy + TILE - 1) / TILE);
    pos_x_d = blocked ? pos_x_q : cx[9:0];
    pos_y_d = blocked ? pos_y_q : cy[9:0];
  end

  assign active    = (fsm_q == ST_ALIVE) || (fsm_q == ST_INVULN);
  assign fatal_hit = hit && (fsm_q == ST_ALIVE) && (hp_q <= 2'd1);
  assign fire_ok   = fire && (fire_cd_q == '0) && active && !fatal_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x_q       <= INIX;
      pos_y_q       <= INIY;
      dir_q         <= 2'b00;
      hp_q          <= HP0;
      lives_q       <= LIVES0;
      fsm_q         <= ST_INVULN;
      inv_cnt_q     <= INV0;
      rsp_cnt_q     <= '0;
      fire_cd_q     <= '0;
      move_cnt_q    <= MOVE_LAST;
      bullet_fire_q <= 1'b0;
      bullet_dir_q  <= 2'b00;
      anim_q        <= 3'd0;
    end else if (game_over) begin
      bullet_fire_q <= 1'b0;
    end else begin
      bullet_fire_q <= fire_ok;
      if (fire_ok) begin
        bullet_dir_q <= dir_q;
        fire_cd_q    <= FC0;
      end else if (tick && fire_cd_q != '0) begin
        fire_cd_q <= fire_cd_q - 1'b1;
      end

      if (tick && active && !fatal_hit) begin
        if (!any_dir) begin
          if (move_cnt_q != MOVE_LAST) move_cnt_q <= move_cnt_q + 1'b1;
        end else if (move_cnt_q == MOVE_LAST) begin
          move_cnt_q <= '0;
          dir_q      <= req_dir;
          pos_x_q    <= pos_x_d;
          pos_y_q    <= pos_y_d;
          if (!blocked) anim_q <= anim_q + 3'd1;
        end else begin
          move_cnt_q <= move_cnt_q + 1'b1;
        end
      end

      case (fsm_q)
        ST_ALIVE: if (hit) begin
          hp_q <= hp_q - 2'd1;
          if (hp_q > 2'd1) begin
            fsm_q     <= ST_INVULN;
            inv_cnt_q <= INV0;
          end else begin
            lives_q <= lives_q - 3'd1;
            if (lives_q <= 3'd1) begin
              fsm_q <= ST_OUT;
            end else begin
              fsm_q     <= ST_DEAD;
              rsp_cnt_q <= RSP0;
            end
          end
        end
        ST_INVULN: if (tick) begin
          if (inv_cnt_q <= IVW'(1)) begin
            inv_cnt_q <= '0;
            fsm_q     <= ST_ALIVE;
          end else begin
            inv_cnt_q <= inv_cnt_q - 1'b1;
          end
        end
        // Respawn overrides anything the fire/move paths did this cycle.
        ST_DEAD: if (tick) begin
          if (rsp_cnt_q <= RSW'(1)) begin
            rsp_cnt_q <= '0;
            fsm_q     <= ST_INVULN;
            inv_cnt_q <= INV0;
            pos_x_q   <= INIX;
            pos_y_q   <= INIY;
            dir_q     <= 2'b00;
            hp_q      <= HP0;
            fire_cd_q <= '0;
          end else begin
            rsp_cnt_q <= rsp_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bullet_fire      = bullet_fire_q & ~game_over;
  assign bullet_direction = bullet_dir_q;
  assign pos_x            = pos_x_q;
  assign pos_y            = pos_y_q;
  assign lives_left       = lives_q;
  assign tank_state       = {PIDX, active, pos_x_q, pos_y_q, dir_q, fsm_q, hp_q, anim_q};

endmodule

// File: tb/tb_tank_ctrl_mk2.sv
// tb/tb_tank_ctrl_mk2.sv - directed self-checking bench for tank_ctrl_mk2
module tb_tank_ctrl_mk2;

  logic         clk = 1'b0;
  logic         reset, tick, game_over, hit, up, down, left, right, fire;
  logic [255:0] map_walls;
  logic         bullet_fire;
  logic [1:0]   bullet_direction;
  logic [9:0]   pos_x, pos_y;
  logic [2:0]   lives_left;
  logic [31:0]  tank_state;

  int tests = 0;
  int fails = 0;
  int pulses;

  tank_ctrl_mk2 dut (
    .clk(clk), .reset(reset), .tick(tick), .game_over(game_over), .hit(hit),
    .map_walls(map_walls), .up(up), .down(down), .left(left), .right(right), .fire(fire),
    .bullet_fire(bullet_fire), .bullet_direction(bullet_direction),
    .pos_x(pos_x), .pos_y(pos_y), .lives_left(lives_left), .tank_state(tank_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic act, input logic [9:0] x, input logic [9:0] y,
                                       input logic [1:0] d, input logic [1:0] f,
                                       input logic [1:0] h, input logic [2:0] a);
    return {2'b00, act, x, y, d, f, h, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic wait_fsm(input logic [1:0] s);
    int n;
    n = 0;
    while (tank_state[6:5] !== s && n < 400) begin
      cyc(1'b1);
      n++;
    end
    check("fsm_wait", 32'(n < 400), 32'd1);
  endtask

  task automatic hit_when_alive();
    wait_fsm(2'b00);
    hit = 1'b1;
    cyc(1'b0);
    hit = 1'b0;
  endtask

  task automatic lose_life();
    for (int k = 0; k < 3; k++) hit_when_alive();
    wait_fsm(2'b01);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; game_over = 1'b0; hit = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; fire = 1'b0;
    map_walls = '0;
    for (int ty = 0; ty < 16; ty++)
      for (int tx = 0; tx < 16; tx++)
        if (ty == 0 || ty == 15 || tx == 0 || tx == 15) map_walls[ty*16+tx] = 1'b1;

    cyc(1'b0);
    cyc(1'b0);
    check("rst_state", tank_state, word(1'b1, 10'd32, 10'd32, 2'd0, 2'd1, 2'd3, 3'd0));
    check("rst_lives", 32'(lives_left), 32'd3);
    check("rst_bfire", 32'(bullet_fire), 32'd0);
    check("rst_bdir", 32'(bullet_direction), 32'd0);

    // Open interior, hold right.
    reset = 1'b0;
    right = 1'b1;
    cyc(1'b1);
    check("mv_t1_x", 32'(pos_x), 32'd36);
    check("mv_t1_anim", 32'(tank_state[2:0]), 32'd1);
    cyc(1'b1);
    check("mv_t2_x", 32'(pos_x), 32'd36);
    cyc(1'b1);
    check("mv_t3_state", tank_state, word(1'b1, 10'd40, 10'd32, 2'd3, 2'd1, 2'd3, 3'd2));
    cyc(1'b0);
    check("mv_notick_x", 32'(pos_x), 32'd40);
    right = 1'b0;

    // Asynchronous reset between clock edges.
    reset = 1'b1;
    #2;
    check("async_rst_state", tank_state, word(1'b1, 10'd32, 10'd32, 2'd0, 2'd1, 2'd3, 3'd0));
    cyc(1'b0);
    map_walls[1*16+2] = 1'b1;
    reset = 1'b0;

    // Wall at tile (2,1) blocks right; border blocks up.
    right = 1'b1;
    cyc(1'b1);
    check("wall_x", 32'(pos_x), 32'd32);
    check("wall_dir", 32'(tank_state[8:7]), 32'd3);
    ticks(2);
    check("wall_x2", 32'(pos_x), 32'd32);
    check("wall_anim", 32'(tank_state[2:0]), 32'd0);
    right = 1'b0;
    up = 1'b1;
    cyc(1'b1);
    check("up_pace_dir", 32'(tank_state[8:7]), 32'd3);
    cyc(1'b1);
    check("up_y", 32'(pos_y), 32'd32);
    check("up_dir", 32'(tank_state[8:7]), 32'd0);
    up = 1'b0;
    map_walls[1*16+2] = 1'b0;

    // Turn left (blocked by border) so dir = 10, then hold fire.
    left = 1'b1;
    ticks(2);
    check("left_dir", 32'(tank_state[8:7]), 32'd2);
    check("left_x", 32'(pos_x), 32'd32);
    left = 1'b0;
    fire = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      if (bullet_fire === 1'b1) pulses++;
      if (i == 0) begin
        check("fire_first", 32'(bullet_fire), 32'd1);
        check("fire_dir", 32'(bullet_direction), 32'd2);
      end
      if (i == 1) check("fire_one_cycle", 32'(bullet_fire), 32'd0);
    end
    check("fire_pulses", 32'(pulses), 32'd3);

    // game_over mid-cooldown (7 ticks remaining).
    game_over = 1'b1;
    right = 1'b1;
    hit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      check("go_bfire", 32'(bullet_fire), 32'd0);
    end
    check("go_state", tank_state, word(1'b1, 10'd32, 10'd32, 2'd2, 2'd1, 2'd3, 3'd0));
    check("go_lives", 32'(lives_left), 32'd3);
    game_over = 1'b0;
    right = 1'b0;
    hit = 1'b0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1);
      if (bullet_fire === 1'b1) pulses++;
    end
    check("go_cd_held", 32'(pulses), 32'd0);
    cyc(1'b1);
    check("go_cd_fire", 32'(bullet_fire), 32'd1);
    fire = 1'b0;

    // First life: hits, invulnerability timing, death and respawn.
    wait_fsm(2'b00);
    check("alive_fsm", 32'(tank_state[6:5]), 32'd0);
    hit = 1'b1;
    cyc(1'b0);
    check("hit1_hp", 32'(tank_state[4:3]), 32'd2);
    check("hit1_fsm", 32'(tank_state[6:5]), 32'd1);
    cyc(1'b1);
    hit = 1'b0;
    check("inv_hit_hp", 32'(tank_state[4:3]), 32'd2);
    right = 1'b1;
    ticks(4);
    check("life1_x", 32'(pos_x), 32'd40);
    right = 1'b0;
    ticks(54);
    check("inv_59", 32'(tank_state[6:5]), 32'd1);
    cyc(1'b1);
    check("inv_60", 32'(tank_state[6:5]), 32'd0);
    hit = 1'b1;
    cyc(1'b0);
    hit = 1'b0;
    check("hit2_hp", 32'(tank_state[4:3]), 32'd1);
    hit_when_alive();
    check("dead_state", tank_state, word(1'b0, 10'd40, 10'd32, 2'd3, 2'd2, 2'd0, 3'd2));
    check("dead_lives", 32'(lives_left), 32'd2);
    right = 1'b1;
    fire = 1'b1;
    cyc(1'b1);
    check("dead_x", 32'(pos_x), 32'd40);
    check("dead_nofire", 32'(bullet_fire), 32'd0);
    right = 1'b0;
    fire = 1'b0;
    ticks(118);
    check("rsp_119", 32'(tank_state[6:5]), 32'd2);
    cyc(1'b1);
    check("rsp_120", tank_state[29:3], 27'(word(1'b1, 10'd32, 10'd32, 2'd0, 2'd1, 2'd3, 3'd0) >> 3));

    // Second death, then reset while dead.
    for (int k = 0; k < 3; k++) hit_when_alive();
    check("dead2_fsm", 32'(tank_state[6:5]), 32'd2);
    check("dead2_lives", 32'(lives_left), 32'd1);
    ticks(5);
    reset = 1'b1;
    #2;
    check("dead_rst_state", tank_state, word(1'b1, 10'd32, 10'd32, 2'd0, 2'd1, 2'd3, 3'd0));
    check("dead_rst_lives", 32'(lives_left), 32'd3);
    check("dead_rst_bdir", 32'(bullet_direction), 32'd0);
    cyc(1'b0);
    reset = 1'b0;

    // Run out of lives; the fatal hit arrives with fire held.
    lose_life();
    lose_life();
    check("last_life", 32'(lives_left), 32'd1);
    hit_when_alive();
    hit_when_alive();
    check("last_hp", 32'(tank_state[4:3]), 32'd1);
    wait_fsm(2'b00);
    hit = 1'b1;
    fire = 1'b1;
    cyc(1'b0);
    hit = 1'b0;
    check("out_fsm", 32'(tank_state[6:5]), 32'd3);
    check("out_active", 32'(tank_state[29]), 32'd0);
    check("out_lives", 32'(lives_left), 32'd0);
    check("out_nofire", 32'(bullet_fire), 32'd0);
    right = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1);
      if (bullet_fire === 1'b1) pulses++;
    end
    check("out_pulses", 32'(pulses), 32'd0);
    check("out_x", 32'(pos_x), 32'd32);
    check("out_fsm_hold", 32'(tank_state[6:5]), 32'd3);
    right = 1'b0;
    fire = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
